stack_run_controller: RTL and testbench

- Job sequencer that owns one stack processor core and runs a single program to completion per request.
- Sequence per job:
  - Latch the host's start address and two input operands.
  - Hold the core in reset for a fixed number of cycles, then release it.
  - Detect halt from a stalled instruction count. Enforce an optional cycle timeout and a host abort.
  - Capture top/second of stack and the instruction count.
  - Report completion with a status code.
- Sits between the host/test harness and the processor's CLK/reset/pc_reset_address/getin/getin2 interface.

---
 rtl/stack_run_controller.sv | 171 +++++++++++++++++
 tb/tb_stack_run_controller.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_run_controller.sv
// Job sequencer for one stack processor core: latches a job, pulses core reset,
// watches for halt/timeout/abort, captures the stack and reports a status code.
module stack_run_controller #(
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned HALT_WINDOW  = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] start_addr,
    input  logic [15:0] arg0,
    input  logic [15:0] arg1,
    input  logic [31:0] timeout_cycles,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status,
    output logic [15:0] result_top,
    output logic [15:0] result_second,
    output logic [31:0] result_icount,
    output logic [31:0] run_cycles,
    output logic        proc_reset,
    output logic [15:0] proc_pc_reset_address,
    output logic [15:0] proc_getin,
    output logic [15:0] proc_getin2,
    input  logic [15:0] proc_top_of_stack,
    input  logic [15:0] proc_second_of_stack,
    input  logic [31:0] proc_inst_count
);

    localparam int unsigned RCW = $clog2(RESET_CYCLES + 1);
    localparam int unsigned HWW = $clog2(HALT_WINDOW + 1);

    localparam logic [1:0] ST_HALT    = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_ABORT   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRST,
        S_RUN,
        S_CAPT,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [RCW-1:0] rst_cnt;
    logic [HWW-1:0] stall_cnt;
    logic [31:0]    prev_icount;
    logic [31:0]    timeout_q;
    logic [1:0]     exit_code;

    logic [HWW-1:0] stall_nx_c;
    logic [31:0]    run_inc_c;
    logic           halt_c;
    logic           timeout_c;
    logic [1:0]     exit_code_c;

    // State register
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state plus halt/timeout/abort detection
    always_comb begin
        state_nx    = state;
        exit_code_c = ST_HALT;
        run_inc_c   = (run_cycles == 32'hFFFF_FFFF) ? run_cycles : run_cycles + 32'd1;
        stall_nx_c  = ((proc_inst_count == prev_icount) && (proc_inst_count != 32'd0))
                      ? stall_cnt + HWW'(1) : HWW'(0);
        halt_c      = (stall_nx_c == HWW'(HALT_WINDOW));
        timeout_c   = (timeout_q != 32'd0) && (run_inc_c == timeout_q);

        unique case (state)
            S_IDLE: begin
                if (start) state_nx = S_PRST;
            end
            S_PRST: begin
                if (abort) begin
                    state_nx    = S_CAPT;
                    exit_code_c = ST_ABORT;
                end else if (rst_cnt == RCW'(0)) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_nx    = S_CAPT;
                    exit_code_c = ST_ABORT;
                end else if (halt_c) begin
                    state_nx    = S_CAPT;
                    exit_code_c = ST_HALT;
                end else if (timeout_c) begin
                    state_nx    = S_CAPT;
                    exit_code_c = ST_TIMEOUT;
                end
            end
            S_CAPT:  state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Registered outputs, job latches and counters
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            busy                  <= 1'b0;
            done                  <= 1'b0;
            status                <= ST_HALT;
            result_top            <= 16'd0;
            result_second         <= 16'd0;
            result_icount         <= 32'd0;
            run_cycles            <= 32'd0;
            proc_reset            <= 1'b1;
            proc_pc_reset_address <= 16'd0;
            proc_getin            <= 16'd0;
            proc_getin2           <= 16'd0;
            rst_cnt               <= RCW'(0);
            stall_cnt             <= HWW'(0);
            prev_icount           <= 32'd0;
            timeout_q             <= 32'd0;
            exit_code             <= ST_HALT;
        end else begin
            busy <= (state_nx != S_IDLE);
            done <= (state_nx == S_DONE);
            // Core stays in reset through CAPT when the job never left PRST
            proc_reset <= !((state_nx == S_RUN) ||
                            ((state_nx == S_CAPT) && (state == S_RUN)));

            if (((state == S_PRST) || (state == S_RUN)) && (state_nx == S_CAPT)) begin
                exit_code <= exit_code_c;
            end

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        proc_pc_reset_address <= start_addr;
                        proc_getin            <= arg0;
                        proc_getin2           <= arg1;
                        timeout_q             <= timeout_cycles;
                        run_cycles            <= 32'd0;
                        stall_cnt             <= HWW'(0);
                        prev_icount           <= 32'd0;
                        rst_cnt               <= RCW'(RESET_CYCLES - 1);
                    end
                end
                S_PRST: begin
                    if (rst_cnt != RCW'(0)) rst_cnt <= rst_cnt - RCW'(1);
                end
                S_RUN: begin
                    run_cycles  <= run_inc_c;
                    stall_cnt   <= stall_nx_c;
                    prev_icount <= proc_inst_count;
                end
                S_CAPT: begin
                    result_top    <= proc_top_of_stack;
                    result_second <= proc_second_of_stack;
                    result_icount <= proc_inst_count;
                    status        <= exit_code;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_run_controller.sv
// Bench for stack_run_controller: a tiny stack-core model plus a scoreboard of
// expected job results compared on each done pulse.
module tb_stack_run_controller;

    localparam int unsigned HALT_WINDOW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] start_addr = '0;
    logic [15:0] arg0 = '0;
    logic [15:0] arg1 = '0;
    logic [31:0] timeout_cycles = '0;
    logic        abort = 1'b0;
    logic        busy, done;
    logic [1:0]  status;
    logic [15:0] result_top, result_second;
    logic [31:0] result_icount, run_cycles;
    logic        proc_reset;
    logic [15:0] proc_pc_reset_address, proc_getin, proc_getin2;
    logic [15:0] proc_top_of_stack, proc_second_of_stack;
    logic [31:0] proc_inst_count;

    stack_run_controller #(.RESET_CYCLES(2), .HALT_WINDOW(HALT_WINDOW)) dut (
        .CLK                   (clk),
        .reset                 (rst_n),
        .start                 (start),
        .start_addr            (start_addr),
        .arg0                  (arg0),
        .arg1                  (arg1),
        .timeout_cycles        (timeout_cycles),
        .abort                 (abort),
        .busy                  (busy),
        .done                  (done),
        .status                (status),
        .result_top            (result_top),
        .result_second         (result_second),
        .result_icount         (result_icount),
        .run_cycles            (run_cycles),
        .proc_reset            (proc_reset),
        .proc_pc_reset_address (proc_pc_reset_address),
        .proc_getin            (proc_getin),
        .proc_getin2           (proc_getin2),
        .proc_top_of_stack     (proc_top_of_stack),
        .proc_second_of_stack  (proc_second_of_stack),
        .proc_inst_count       (proc_inst_count)
    );

    always #5 clk = ~clk;

    // ---------------- tiny stack core model ----------------
    localparam int OP_NOP = 0, OP_GETIN = 1, OP_GETIN2 = 2, OP_PUSHI = 3, OP_HALT = 4,
                   OP_ADDI = 5, OP_DECJNZ = 6, OP_JAL = 7, OP_RET = 8;
    int          op  [0:31];
    logic [15:0] imm [0:31];
    logic [15:0] pc, ra, t_q, s_q;
    logic [31:0] icnt;
    logic        halted;

    assign proc_top_of_stack    = t_q;
    assign proc_second_of_stack = s_q;
    assign proc_inst_count      = icnt;

    always @(posedge clk) begin
        if (proc_reset) begin
            pc <= proc_pc_reset_address; ra <= '0; t_q <= '0; s_q <= '0;
            icnt <= '0; halted <= 1'b0;
        end else if (!halted) begin
            icnt <= icnt + 32'd1;
            pc   <= pc + 16'd1;
            case (op[pc[4:0]])
                OP_GETIN:  begin s_q <= t_q; t_q <= proc_getin; end
                OP_GETIN2: begin s_q <= t_q; t_q <= proc_getin2; end
                OP_PUSHI:  begin s_q <= t_q; t_q <= imm[pc[4:0]]; end
                OP_HALT:   begin halted <= 1'b1; pc <= pc; end
                OP_ADDI:   t_q <= t_q + imm[pc[4:0]];
                OP_DECJNZ: begin
                    s_q <= s_q - 16'd1;
                    if (s_q != 16'd1) pc <= imm[pc[4:0]];
                end
                OP_JAL:    begin ra <= pc + 16'd1; pc <= imm[pc[4:0]]; end
                OP_RET:    pc <= ra;
                default:   ;
            endcase
        end
    end

    // ---------------- checking and scoreboard ----------------
    typedef struct {
        logic [1:0]  st;
        logic [15:0] top;
        logic [15:0] sec;
        logic [31:0] ic;
        logic [31:0] rc;
        bit          chk_data;
        bit          chk_rc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("status", 32'(status), 32'(e.st));
                check("busy_in_done", 32'(busy), 32'd1);
                check("proc_reset_in_done", 32'(proc_reset), 32'd1);
                if (e.chk_data) begin
                    check("result_top", 32'(result_top), 32'(e.top));
                    check("result_second", 32'(result_second), 32'(e.sec));
                    check("result_icount", result_icount, e.ic);
                end
                if (e.chk_rc) check("run_cycles", run_cycles, e.rc);
            end
        end
    end

    function automatic exp_t mk(input logic [1:0] st, input logic [15:0] top, input logic [15:0] sec,
                                input logic [31:0] ic, input logic [31:0] rc,
                                input bit cd, input bit cr);
        exp_t e;
        e.st = st; e.top = top; e.sec = sec; e.ic = ic; e.rc = rc; e.chk_data = cd; e.chk_rc = cr;
        return e;
    endfunction

    task automatic launch(input logic [15:0] addr, input logic [15:0] a0, input logic [15:0] a1,
                          input logic [31:0] tmo, input exp_t e);
        @(negedge clk);
        sb.push_back(e);
        start = 1'b1; start_addr = addr; arg0 = a0; arg1 = a1; timeout_cycles = tmo;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            check({tag, "_wait_expired"}, 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    initial begin
        int cnt, t2, td, idx;
        bit released;

        for (int i = 0; i < 32; i++) begin op[i] = OP_NOP; imm[i] = '0; end
        op[0] = OP_GETIN; op[1] = OP_GETIN2; op[2] = OP_HALT;
        op[3] = OP_JAL;   imm[3] = 16'd6;
        op[4] = OP_PUSHI; imm[4] = 16'd9;
        op[5] = OP_HALT;
        op[6] = OP_PUSHI; imm[6] = 16'd5;
        op[7] = OP_RET;
        op[8] = OP_PUSHI; imm[8] = 16'd2;
        op[9] = OP_HALT;
        op[10] = OP_PUSHI; imm[10] = 16'd3;
        op[11] = OP_PUSHI; imm[11] = 16'd5;
        op[12] = OP_PUSHI; imm[12] = 16'd1;
        op[15] = OP_ADDI;  imm[15] = 16'd1;
        op[16] = OP_DECJNZ; imm[16] = 16'd13;
        op[17] = OP_HALT;

        // reset state
        #12;
        check("rst_proc_reset", 32'(proc_reset), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_status", 32'(status), 32'd0);
        check("rst_run_cycles", run_cycles, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // halted job: getin; getin2; halt
        launch(16'd0, 16'd3, 16'd4, 32'd0, mk(2'b00, 16'd4, 16'd3, 32'd3, 32'd0, 1, 0));
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (proc_reset) cnt++;
            else break;
        end
        check("prst_cycles", 32'(cnt), 32'd2);
        wait_idle("halted", 200);

        // halt detection latency: pushi 2; halt; pushi 3
        launch(16'd8, 16'd0, 16'd0, 32'd0, mk(2'b00, 16'd2, 16'd0, 32'd2, 32'd0, 1, 0));
        t2 = -1; td = -1;
        for (int i = 0; i < 100 && td < 0; i++) begin
            @(negedge clk);
            if (t2 < 0 && !proc_reset && proc_inst_count == 32'd2) t2 = cyc;
            if (done) td = cyc;
        end
        check("halt_latency", 32'(td - t2), 32'(HALT_WINDOW + 2));
        wait_idle("halt_det", 200);

        // timeout on a 5-iteration loop
        launch(16'd11, 16'd0, 16'd0, 32'd20, mk(2'b01, 16'd0, 16'd0, 32'd0, 32'd20, 0, 1));
        idx = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (idx == 0 && !proc_reset) idx = 1;
            else if (idx > 0) idx++;
            if (done) break;
        end
        check("timeout_done_idx", 32'(idx), 32'd22);
        wait_idle("timeout", 200);

        // same loop without a limit runs to halt
        launch(16'd11, 16'd0, 16'd0, 32'd0, mk(2'b00, 16'd6, 16'd0, 32'd23, 32'd28, 1, 1));
        wait_idle("loop_halt", 300);

        // abort in second PRST cycle
        launch(16'd0, 16'd1, 16'd2, 32'd0, mk(2'b10, 16'd0, 16'd0, 32'd0, 32'd0, 1, 1));
        released = 0;
        @(negedge clk);
        if (!proc_reset) released = 1;
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cnt++;
            if (!proc_reset) released = 1;
            if (done) break;
        end
        check("prst_abort_done_delay", 32'(cnt), 32'd2);
        check("prst_abort_core_released", 32'(released), 32'd0);
        wait_idle("prst_abort", 50);

        // abort in the same RUN cycle halt is declared (RUN cycle 7)
        launch(16'd8, 16'd0, 16'd0, 32'd0, mk(2'b10, 16'd2, 16'd0, 32'd2, 32'd7, 1, 1));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!proc_reset) break;
        end
        repeat (6) @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        wait_idle("abort_halt", 100);

        // start while busy and in the DONE cycle are ignored
        launch(16'd0, 16'd7, 16'd8, 32'd0, mk(2'b00, 16'd8, 16'd7, 32'd3, 32'd0, 1, 0));
        repeat (4) @(negedge clk);
        start = 1'b1; start_addr = 16'd5;
        repeat (3) @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) break;
        end
        start = 1'b1; start_addr = 16'd5;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("start_in_done_ignored", 32'(busy), 32'd0);
        check("addr_unchanged", 32'(proc_pc_reset_address), 32'd0);
        wait_idle("busy_start", 50);

        // fresh job at start_addr 3: jal/return program
        launch(16'd3, 16'd0, 16'd0, 32'd0, mk(2'b00, 16'd9, 16'd5, 32'd5, 32'd0, 1, 0));
        check("new_start_addr", 32'(proc_pc_reset_address), 32'd3);
        wait_idle("jal", 200);

        // asynchronous reset in the middle of RUN
        launch(16'd11, 16'd0, 16'd0, 32'd0, mk(2'b00, 16'd0, 16'd0, 32'd0, 32'd0, 0, 0));
        repeat (8) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_proc_reset", 32'(proc_reset), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_top", 32'(result_top), 32'd0);
        check("mid_rst_second", 32'(result_second), 32'd0);
        check("mid_rst_icount", result_icount, 32'd0);
        check("mid_rst_run_cycles", run_cycles, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
